// File: rtl/serial_add_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_add_pkg                                                   |
// | Shared state encoding and default width for serial_add_ctrl.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_fa_cell                                                   |
// | One-bit combinational full adder shared across all bit slots.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_add_ctrl                                                  |
// | Bit-serial add/subtract sequencer, LSB first, start/busy/done.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_accept;
  logic             w_last;

  serial_fa_cell u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_s),
    .o_cout (w_fa_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on load and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= {w_fa_s, r_acc[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_fa_c;
      if (w_last) begin
        r_cnt  <= '0;
        r_sum  <= {w_fa_s, r_acc[WIDTH-1:1]};
        r_cout <= w_fa_c;
        r_ovf  <= w_fa_c ^ r_carry;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_serial_add_ctrl                                               |
// | Scoreboard bench: arithmetic reference model plus output monitor.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  res_t exp_mem [16];
  int   wr = 0;
  int   rd = 0;
  int   m_rem = 0;
  int   checks = 0;
  int   errors = 0;
  bit   end_req = 1'b0;
  res_t m_hold = '0;

  function automatic res_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t r;
    int   ux = int'(x);
    int   uy = int'(y);
    int   sx = int'($signed(x));
    int   sy = int'($signed(y));
    int   ur = s ? ux - uy : ux + uy;
    int   sr = s ? sx - sy : sx + sy;
    r.s = ur[W-1:0];
    r.c = s ? (ux >= uy) : (ur >= (1 << W));
    r.v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return r;
  endfunction

  // Request model: accepted only when idle; busy for W+1 cycles after acceptance.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem <= 0;
    end else if (m_rem == 0) begin
      if (start) begin
        exp_mem[wr % 16] <= ref_op(a, b, sub);
        wr    <= wr + 1;
        m_rem <= W + 1;
      end
    end else begin
      m_rem <= m_rem - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (end_req) begin
        chk("queue_drained", 32'(wr - rd), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (!rst_n) begin
        rd     = wr;
        m_hold = '0;
      end
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("done", 32'(done), 32'(m_rem == 1));
      if ((done === 1'b1 || m_rem == 1) && rd != wr) begin
        m_hold = exp_mem[rd % 16];
        rd++;
      end
      chk("sum", 32'(sum), 32'(m_hold.s));
      chk("cout", 32'(cout), 32'(m_hold.c));
      chk("ovf", 32'(ovf), 32'(m_hold.v));
    end
  end

  // Issue one request at the current negedge, then W+1 cycles of scrambled inputs.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                       input bit hold_start);
    a = ta; b = tb2; sub = ts; start = 1'b1;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      start = hold_start;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin : driver
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'h10, 8'h20, 1'b1, 1'b0);
    idle(2);
    issue(8'h80, 8'h01, 1'b1, 1'b0);
    idle(1);
    issue(8'h01, 8'h01, 1'b0, 1'b1);
    idle(1);

    a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    issue(8'h03, 8'h04, 1'b0, 1'b0);
    idle(1);

    for (int i = 0; i < 4 * (W + 2); i++) begin
      start = 1'b1;
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    idle(W + 2);

    for (int n = 0; n < 30; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom));
      idle($urandom_range(0, 3));
    end

    idle(W + 3);
    end_req = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL monitor_timeout: summary not reached, got none expected summary");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer for the switch/LED board designs.
- Time-multiplexes a single one-bit full-adder cell, plus a carry flip-flop, over WIDTH-bit operands, least significant bit first.
- Provides a start/busy/done handshake and registered result, carry and overflow outputs.
- Replaces a ripple chain of full-adder instances when operand width grows.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request an operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
- sum  output  WIDTH  last completed result, held until the next completion.
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement overflow (carry into MSB xor carry out of MSB).

Behaviour:
- Reset (rst_n low at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; bit counter, operand shift registers and carry flop cleared.
- Reset mid-operation: the operation is abandoned, no done pulse, outputs go to reset values.
- Reset overrides start.
- States:
  - IDLE: start=1 at edge E0 → latch a into shift register A and (b xor {WIDTH{sub}}) into shift register B; carry=sub; cnt=0; go to RUN. start=0 → stay.
  - RUN: each edge computes s,c = FA(A[0], B[0], carry); shifts s into the MSB of the sum shift register; shifts A and B right by one; carry=c; cnt=cnt+1.
    - On the edge processing bit WIDTH-1: save the carry into the MSB (value before update) for ovf; load the sum/cout/ovf output registers; done=1; go to DONE.
  - DONE: next edge → IDLE, done=0.
- Latency:
  - Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
  - done is high for exactly the cycle after E_WIDTH.
  - busy is high from after E0 through the DONE cycle, i.e. WIDTH+1 cycles.
  - Next start is accepted at edge E_WIDTH+2 at the earliest.
- start while busy (RUN or DONE): ignored, no queuing; a, b and sub changes during RUN have no effect.
- sum/cout/ovf change only at the completion edge; they hold the previous result throughout RUN.
- Arithmetic is modulo 2^WIDTH.
  - ovf: signed overflow.
  - cout: unsigned carry, or inverted borrow when sub=1.
- Counter width: clog2(WIDTH). No wrap beyond WIDTH-1 is permitted.
- start held high continuously: back-to-back operations every WIDTH+2 cycles.

Decomposition:
- Package serial_add_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- One natural sub-module, serial_fa_cell: purely combinational 1-bit full adder (a, b, cin → sum, cout), instantiated once.
- Shift registers, counter and FSM stay in serial_add_ctrl.

Test Plan (WIDTH=8):
- Add with signed overflow: a=8'h5A, b=8'h3C, sub=0, start pulse → done exactly 8 cycles after accepting edge; sum=8'h96, cout=0, ovf=1; busy high 9 cycles.
- Unsigned carry: a=8'hFF, b=8'h01, sub=0 → sum=8'h00, cout=1, ovf=0.
- Subtract with borrow: a=8'h10, b=8'h20, sub=1 → sum=8'hF0, cout=0, ovf=0.
- Subtract with signed overflow: a=8'h80, b=8'h01, sub=1 → sum=8'h7F, cout=1, ovf=1.
- Start and operand changes while busy:
  - start 8'h01+8'h01, then assert start with a=8'hFF, b=8'hFF during RUN and change a/b every cycle;
  - required: single done with sum=8'h02, cout=0;
  - required: sum holds its previous value until the completion edge;
  - required: the second request is not serviced.
- Reset mid-operation: rst_n low at cycle 4 of RUN for 1 cycle → no done, busy=0, sum=0, cout=0, ovf=0; next start 8'h03+8'h04 → sum=8'h07.
